// File: rtl/uart_tx_arbiter.sv
// Two-requester arbiter in front of a single UART transmitter: grants, starts, waits for ack/done.
// Optional macro UART_ARB_FIXED_PRIO_EN: requester 1 always wins ties instead of round-robin.
module uart_tx_arbiter #(
    parameter int DATA_W      = 8,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              req1_i,
    input  logic [DATA_W-1:0] data1_i,
    input  logic              req2_i,
    input  logic [DATA_W-1:0] data2_i,
    input  logic              tx_busy_i,
    output logic              tx_start_o,
    output logic [DATA_W-1:0] tx_data_o,
    output logic              grant_o,
    output logic              done1_o,
    output logic              done2_o,
    output logic              err1_o,
    output logic              err2_o,
    output logic              busy_o
);
    typedef enum logic [1:0] {IDLE, START, WAIT_ACK, WAIT_DONE} state_t;

    localparam logic [7:0] TIMEOUT = 8'(ACK_TIMEOUT);

    state_t              state_reg;
    logic [7:0]          cnt_reg;
    logic [7:0]          cnt_next;
    logic                ack_expired;
    logic                pick2;
    logic                tx_start_reg;
    logic [DATA_W-1:0]   tx_data_reg;
    logic                grant_reg;
    logic                done1_reg;
    logic                done2_reg;
    logic                err1_reg;
    logic                err2_reg;
    logic                busy_reg;

    assign cnt_next    = cnt_reg + 8'd1;
    assign ack_expired = (cnt_next == TIMEOUT);

`ifdef UART_ARB_FIXED_PRIO_EN
    assign pick2 = !req1_i;
`else
    // Last-served requester: 0 = requester 1, 1 = requester 2. Updated on done or timeout.
    logic last_reg;
    logic xfer_end;

    assign xfer_end = ((state_reg == WAIT_ACK) && !tx_busy_i && ack_expired) ||
                      ((state_reg == WAIT_DONE) && !tx_busy_i);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_reg <= 1'b0;
        end else if (xfer_end) begin
            last_reg <= grant_reg;
        end
    end

    assign pick2 = req2_i && (!req1_i || !last_reg);
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            tx_start_reg <= 1'b0;
            tx_data_reg  <= '0;
            grant_reg    <= 1'b0;
            done1_reg    <= 1'b0;
            done2_reg    <= 1'b0;
            err1_reg     <= 1'b0;
            err2_reg     <= 1'b0;
            busy_reg     <= 1'b0;
        end else begin
            tx_start_reg <= 1'b0;
            done1_reg    <= 1'b0;
            done2_reg    <= 1'b0;
            err1_reg     <= 1'b0;
            err2_reg     <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (req1_i || req2_i) begin
                        grant_reg    <= pick2;
                        tx_data_reg  <= pick2 ? data2_i : data1_i;
                        tx_start_reg <= 1'b1;
                        busy_reg     <= 1'b1;
                        state_reg    <= START;
                    end
                end
                START: begin
                    cnt_reg   <= '0;
                    state_reg <= WAIT_ACK;
                end
                WAIT_ACK: begin
                    if (tx_busy_i) begin
                        state_reg <= WAIT_DONE;
                    end else begin
                        cnt_reg <= cnt_next;
                        if (ack_expired) begin
                            err1_reg  <= !grant_reg;
                            err2_reg  <= grant_reg;
                            busy_reg  <= 1'b0;
                            state_reg <= IDLE;
                        end
                    end
                end
                WAIT_DONE: begin
                    if (!tx_busy_i) begin
                        done1_reg <= !grant_reg;
                        done2_reg <= grant_reg;
                        busy_reg  <= 1'b0;
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign tx_start_o = tx_start_reg;
    assign tx_data_o  = tx_data_reg;
    assign grant_o    = grant_reg;
    assign done1_o    = done1_reg;
    assign done2_o    = done2_reg;
    assign err1_o     = err1_reg;
    assign err2_o     = err2_reg;
    assign busy_o     = busy_reg;
endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter: DATA_W, 8, width of the byte presented by each requester and forwarded to the UART transmitter.
REQ-002 Parameter: ACK_TIMEOUT, 16, maximum cycles to wait for tx_busy_i to rise after a start pulse; legal range 2..255.
REQ-003 clk_i  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_ni  input  1  reset, asynchronous, active-low.
REQ-005 req1_i  input  1  requester 1 level request; held until done1_o or err1_o.
REQ-006 data1_i  input  DATA_W  requester 1 byte; valid while req1_i is high.
REQ-007 req2_i  input  1  requester 2 level request; same rules as req1_i.
REQ-008 data2_i  input  DATA_W  requester 2 byte.
REQ-009 tx_busy_i  input  1  UART transmitter busy flag.
REQ-010 tx_start_o  output  1  one-cycle start pulse to the UART transmitter.
REQ-011 tx_data_o  output  DATA_W  latched byte of the granted requester.
REQ-012 grant_o  output  1  select for the completion demux: 0 = requester 1, 1 = requester 2.
REQ-013 done1_o, done2_o  output  1 each  one-cycle completion pulse to the granted requester.
REQ-014 err1_o, err2_o  output  1 each  one-cycle timeout pulse to the granted requester.
REQ-015 busy_o  output  1  high in every state except IDLE.

Function
REQ-016 The FSM shall have four states: IDLE, START, WAIT_ACK and WAIT_DONE.
REQ-017 In IDLE with any request high, the block shall select a winner, latch its data into tx_data_o, set grant_o, and go to START on the next edge.
REQ-018 Selection shall use round-robin: with both requests high, the requester not served last wins; after reset, requester 1 counts as last served.
REQ-019 With only one request high, that requester shall win regardless of history.
REQ-020 START shall assert tx_start_o for exactly one cycle, clear the timeout counter, and go to WAIT_ACK.
REQ-021 In WAIT_ACK, tx_busy_i high shall move the FSM to WAIT_DONE.
REQ-022 In WAIT_ACK, the counter shall increment each cycle; when it reaches ACK_TIMEOUT, the block shall pulse the granted err*_o for one cycle and return to IDLE.
REQ-023 In WAIT_DONE, tx_busy_i low shall pulse the granted done*_o for one cycle, record the last-served requester, and return to IDLE.
REQ-024 A timeout shall also record the last-served requester.
REQ-025 Latency from request to tx_start_o shall be 2 cycles (IDLE to START); a new grant shall be possible the cycle after a done or err pulse.
REQ-026 tx_data_o and grant_o shall stay stable from START until return to IDLE.
REQ-027 Request inputs shall be ignored outside IDLE.
REQ-028 A request dropped before completion shall not abort the transfer; the done pulse shall still be issued.
REQ-029 At most one of done1_o, done2_o, err1_o, err2_o shall be high in any cycle.

Reset
REQ-030 Asserting rst_ni low shall immediately force IDLE and set tx_start_o=0, tx_data_o=0, grant_o=0, all done and err outputs=0, busy_o=0, timeout counter=0, and last-served=requester 1.
REQ-031 Reset asserted mid-transfer shall abandon the transfer with no done or err pulse.

Configuration
REQ-032 Macro UART_ARB_FIXED_PRIO_EN: when defined, requester 1 shall always win simultaneous requests and the last-served register is not used.
REQ-033 When UART_ARB_FIXED_PRIO_EN is undefined, round-robin per REQ-018 applies.

Verification
REQ-034 Single request: req1_i=1, data1_i=8'hA5, tx_busy_i rises 1 cycle after start and stays high 10 cycles -> tx_start_o pulses once, tx_data_o=8'hA5, grant_o=0, done1_o pulses once after busy falls.
REQ-035 Simultaneous requests after reset: req1_i=req2_i=1, data 8'h11/8'h22 -> first grant to requester 2 (8'h22) and second to requester 1 (8'h11); with UART_ARB_FIXED_PRIO_EN, requester 1 is served first.
REQ-036 Timeout: req2_i=1, tx_busy_i held 0 -> err2_o pulses exactly ACK_TIMEOUT cycles after WAIT_ACK entry, no done pulse, busy_o=0 the next cycle.
REQ-037 Reset mid-transfer: rst_ni low during WAIT_DONE -> all outputs 0 immediately, no done pulse; after release, a fresh req1_i is served normally.
REQ-038 Back-to-back: req1_i held high across 3 transfers with req2_i=0 -> 3 start pulses, 3 done1_o pulses, grant_o=0 throughout.
